// File: rtl/mdu_iter.sv
// Iterative 32-bit multiply/divide unit: one shift-add or restoring shift-subtract step per cycle,
// result written back through we/wR/wD. Define MDU_SIGNED_EN to enable the signed variants via sgn.
module mdu_iter #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic            sgn,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [4:0]      dest,
  output logic            busy,
  output logic            done,
  output logic            we,
  output logic [4:0]      wR,
  output logic [XLEN-1:0] wD
);

  localparam int            CW   = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_busy;
  logic            r_done;
  logic            r_we;
  logic [4:0]      r_wr;
  logic [XLEN-1:0] r_wd;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_op;
  logic [4:0]      r_dest;
  // r_hi: partial product high word / partial remainder; r_lo: multiplier / dividend -> quotient
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_m;

  logic [XLEN-1:0] w_ma;
  logic [XLEN-1:0] w_mb;
  logic [XLEN:0]   w_sum;
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_diff;
  logic [XLEN-1:0] w_nhi;
  logic [XLEN-1:0] w_nlo;
  logic [XLEN-1:0] w_res;

  assign busy = r_busy;
  assign done = r_done;
  assign we   = r_we;
  assign wR   = r_wr;
  assign wD   = r_wd;

`ifdef MDU_SIGNED_EN
  logic            r_neg;
  logic            w_sa;
  logic            w_sb;
  logic            w_neg;

  // Operand magnitudes and result sign for the signed variants, evaluated at accept
  always_comb begin
    w_sa = sgn & (op != 2'b00) & src_a[XLEN-1];
    w_sb = sgn & (op != 2'b00) & src_b[XLEN-1];
    w_ma = w_sa ? -src_a : src_a;
    w_mb = w_sb ? -src_b : src_b;
    case (op)
      2'b01:   w_neg = w_sa ^ w_sb;
      // A zero divisor keeps the all-ones quotient regardless of the dividend sign
      2'b10:   w_neg = (w_sa ^ w_sb) & (src_b != {XLEN{1'b0}});
      2'b11:   w_neg = w_sa;
      default: w_neg = 1'b0;
    endcase
  end

  // Result select with sign restoration; MULH negates the full 64-bit product
  always_comb begin
    if (!r_neg) begin
      w_res = r_op[0] ? w_nhi : w_nlo;
    end else if (r_op[1]) begin
      w_res = r_op[0] ? -w_nhi : -w_nlo;
    end else begin
      w_res = ~w_nhi + {{(XLEN-1){1'b0}}, (w_nlo == {XLEN{1'b0}})};
    end
  end
`else
  logic w_unused_sgn;

  assign w_unused_sgn = sgn;
  assign w_ma         = src_a;
  assign w_mb         = src_b;
  // Odd ops read the high half (MULHU product / REMU remainder), even ops the low half
  assign w_res        = r_op[0] ? w_nhi : w_nlo;
`endif

  // One iteration step: shift-add for multiply, restoring shift-subtract for divide
  always_comb begin
    w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : {(XLEN+1){1'b0}});
    w_shift = {r_hi, r_lo[XLEN-1]};
    w_diff  = w_shift - {1'b0, r_m};
    if (r_op[1] == 1'b0) begin
      w_nhi = w_sum[XLEN:1];
      w_nlo = {w_sum[0], r_lo[XLEN-1:1]};
    end else if (w_diff[XLEN] == 1'b0) begin
      w_nhi = w_diff[XLEN-1:0];
      w_nlo = {r_lo[XLEN-2:0], 1'b1};
    end else begin
      w_nhi = w_shift[XLEN-1:0];
      w_nlo = {r_lo[XLEN-2:0], 1'b0};
    end
  end

  // Control FSM, datapath registers and registered write-back outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_we    <= 1'b0;
      r_wr    <= 5'd0;
      r_wd    <= {XLEN{1'b0}};
      r_cnt   <= {CW{1'b0}};
      r_op    <= 2'b00;
      r_dest  <= 5'd0;
      r_hi    <= {XLEN{1'b0}};
      r_lo    <= {XLEN{1'b0}};
      r_m     <= {XLEN{1'b0}};
`ifdef MDU_SIGNED_EN
      r_neg   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          r_we   <= 1'b0;
          if (start) begin
            r_state <= S_CALC;
            r_busy  <= 1'b1;
            r_cnt   <= {CW{1'b0}};
            r_op    <= op;
            r_dest  <= dest;
            r_hi    <= {XLEN{1'b0}};
            if (op[1]) begin
              r_m  <= w_mb;
              r_lo <= w_ma;
            end else begin
              r_m  <= w_ma;
              r_lo <= w_mb;
            end
`ifdef MDU_SIGNED_EN
            r_neg   <= w_neg;
`endif
          end else begin
            r_busy <= 1'b0;
          end
        end
        S_CALC: begin
          r_hi  <= w_nhi;
          r_lo  <= w_nlo;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_we    <= (r_dest != 5'd0);
            r_wr    <= r_dest;
            r_wd    <= w_res;
          end else begin
            r_done  <= 1'b0;
            r_we    <= 1'b0;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_we    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_we    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed vector table, handshake/reset sequences and
// randomized operations checked against an arithmetic reference model.
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic        sgn;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [4:0]  dest;
  logic        busy;
  logic        done;
  logic        we;
  logic [4:0]  wR;
  logic [31:0] wD;

  int n_cmp = 0;
  int n_err = 0;

  int          got_done_cnt;
  int          got_k;
  logic        got_we;
  logic [4:0]  got_wr;
  logic [31:0] got_wd;
  int          got_busy_err;

  typedef struct {
    logic [1:0]  op;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  d;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  mdu_iter #(.XLEN(32), .ITER(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .sgn(sgn),
    .src_a(src_a), .src_b(src_b), .dest(dest),
    .busy(busy), .done(done), .we(we), .wR(wR), .wD(wD)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Reference results straight from the arithmetic definitions
  function automatic logic [31:0] ref_model(input logic [1:0] f_op, input logic f_sgn,
                                            input logic [31:0] a, input logic [31:0] b);
    logic [63:0]        p;
    logic signed [63:0] sp;
    logic [31:0]        r;
    p  = {32'd0, a} * {32'd0, b};
    sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    case (f_op)
      2'b00:   r = p[31:0];
      2'b01:   r = p[63:32];
      2'b10:   r = (b == 32'd0) ? 32'hFFFFFFFF : a / b;
      default: r = (b == 32'd0) ? a : a % b;
    endcase
`ifdef MDU_SIGNED_EN
    if (f_sgn) begin
      if (f_op == 2'b01) r = sp[63:32];
      else if (f_op == 2'b10) begin
        if (b == 32'd0) r = 32'hFFFFFFFF;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h80000000;
        else r = $signed(a) / $signed(b);
      end else if (f_op == 2'b11) begin
        if (b == 32'd0) r = a;
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'd0;
        else r = $signed(a) % $signed(b);
      end
    end
`else
    if (f_sgn && sp == 64'sd0) r = r;
`endif
    return r;
  endfunction

  // Launch one operation from IDLE and watch 34 cycles; optionally poke a second start mid-op
  task automatic run_op(input logic [1:0] t_op, input logic t_sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] d, input logic interfere);
    got_done_cnt = 0; got_k = -1; got_we = 1'b0; got_wr = 5'd0; got_wd = 32'd0; got_busy_err = 0;
    start = 1'b1; op = t_op; sgn = t_sgn; src_a = a; src_b = b; dest = d;
    @(posedge clk);
    for (int k = 0; k < 34; k++) begin
      @(negedge clk);
      if (k == 0) begin
        start = 1'b0; src_a = ~a; src_b = a ^ b; dest = ~d; op = ~t_op;
      end
      if (interfere && k == 10) begin
        start = 1'b1; op = 2'b00; src_a = 32'd5; src_b = 32'd5; dest = 5'd3;
      end
      if (interfere && k == 11) start = 1'b0;
      if (busy !== (k < 33)) got_busy_err++;
      if (done === 1'b1) begin
        got_done_cnt++; got_k = k; got_we = we; got_wr = wR; got_wd = wD;
      end else if (we !== 1'b0) begin
        got_busy_err++;
      end
    end
  endtask

  task automatic check_op(input string name, input logic [1:0] t_op, input logic t_sgn,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] d,
                          input logic [31:0] exp);
    run_op(t_op, t_sgn, a, b, d, 1'b0);
    chk({name, ".wD"}, got_wd, exp);
    chk({name, ".done_cnt"}, got_done_cnt, 32'd1);
    chk({name, ".latency"}, got_k, 32'd32);
    chk({name, ".we"}, {31'd0, got_we}, {31'd0, (d != 5'd0)});
    chk({name, ".wR"}, {27'd0, got_wr}, {27'd0, d});
    chk({name, ".busy_win"}, got_busy_err, 32'd0);
  endtask

  initial begin
    logic [1:0]  r_op;
    logic        r_sgn;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [4:0]  rd;
    int          seen_done;
    int          seen_we;

    rst_n = 1'b0; start = 1'b0; op = 2'b00; sgn = 1'b0;
    src_a = 32'd0; src_b = 32'd0; dest = 5'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset.busy", {31'd0, busy}, 32'd0);
    chk("reset.done", {31'd0, done}, 32'd0);
    chk("reset.we", {31'd0, we}, 32'd0);
    chk("reset.wR", {27'd0, wR}, 32'd0);
    chk("reset.wD", wD, 32'd0);
    rst_n = 1'b1;

    vecs.push_back('{2'b00, 1'b0, 32'd7, 32'd6, 5'd5, 32'd42});
    vecs.push_back('{2'b01, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 32'hFFFFFFFE});
    vecs.push_back('{2'b00, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'h00000001});
    vecs.push_back('{2'b10, 1'b0, 32'd100, 32'd7, 5'd3, 32'd14});
    vecs.push_back('{2'b11, 1'b0, 32'd100, 32'd7, 5'd4, 32'd2});
    vecs.push_back('{2'b10, 1'b0, 32'd100, 32'd0, 5'd6, 32'hFFFFFFFF});
    vecs.push_back('{2'b11, 1'b0, 32'd100, 32'd0, 5'd7, 32'd100});
    vecs.push_back('{2'b01, 1'b0, 32'h80000000, 32'd2, 5'd8, 32'd1});
    vecs.push_back('{2'b10, 1'b0, 32'd5, 32'd9, 5'd9, 32'd0});
    vecs.push_back('{2'b11, 1'b0, 32'd5, 32'd9, 5'd31, 32'd5});
    vecs.push_back('{2'b10, 1'b0, 32'hFFFFFFFF, 32'd1, 5'd10, 32'hFFFFFFFF});
    vecs.push_back('{2'b00, 1'b0, 32'd123, 32'd456, 5'd0, 32'd56088});
`ifdef MDU_SIGNED_EN
    vecs.push_back('{2'b10, 1'b1, 32'hFFFFFFF9, 32'd2, 5'd11, 32'hFFFFFFFD});
    vecs.push_back('{2'b11, 1'b1, 32'hFFFFFFF9, 32'd2, 5'd12, 32'hFFFFFFFF});
    vecs.push_back('{2'b10, 1'b1, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h80000000});
    vecs.push_back('{2'b11, 1'b1, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'd0});
    vecs.push_back('{2'b01, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd15, 32'd0});
    vecs.push_back('{2'b01, 1'b1, 32'hFFFFFFFE, 32'd3, 5'd16, 32'hFFFFFFFF});
    vecs.push_back('{2'b10, 1'b1, 32'hFFFFFFF9, 32'd0, 5'd17, 32'hFFFFFFFF});
    vecs.push_back('{2'b11, 1'b1, 32'hFFFFFFF9, 32'd0, 5'd18, 32'hFFFFFFF9});
    vecs.push_back('{2'b00, 1'b1, 32'hFFFFFFFF, 32'd3, 5'd19, 32'hFFFFFFFD});
`else
    vecs.push_back('{2'b10, 1'b1, 32'hFFFFFFF9, 32'd2, 5'd11, 32'h7FFFFFFC});
    vecs.push_back('{2'b01, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd15, 32'hFFFFFFFE});
`endif

    foreach (vecs[i])
      check_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].sgn, vecs[i].a, vecs[i].b,
               vecs[i].d, vecs[i].exp);

    // Second start 10 cycles into a DIVU must be ignored
    run_op(2'b10, 1'b0, 32'd1000, 32'd3, 5'd9, 1'b1);
    chk("ignore.wD", got_wd, 32'd333);
    chk("ignore.wR", {27'd0, got_wr}, 32'd9);
    chk("ignore.done_cnt", got_done_cnt, 32'd1);
    chk("ignore.busy_win", got_busy_err, 32'd0);

    // Reset pulse in the middle of CALC aborts with no write
    start = 1'b1; op = 2'b00; sgn = 1'b0; src_a = 32'd3; src_b = 32'd4; dest = 5'd20;
    @(posedge clk);
    seen_done = 0; seen_we = 0;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      rst_n = (k == 15) ? 1'b0 : 1'b1;
      if (done === 1'b1) seen_done++;
      if (we === 1'b1) seen_we++;
    end
    chk("midrst.busy", {31'd0, busy}, 32'd0);
    chk("midrst.done_seen", seen_done, 32'd0);
    chk("midrst.we_seen", seen_we, 32'd0);
    chk("midrst.wR", {27'd0, wR}, 32'd0);
    chk("midrst.wD", wD, 32'd0);
    check_op("after_rst", 2'b00, 1'b0, 32'd11, 32'd13, 5'd21, 32'd143);

    // Reset and start together: reset wins
    rst_n = 1'b0; start = 1'b1; op = 2'b00; src_a = 32'd2; src_b = 32'd2; dest = 5'd1;
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0;
    @(negedge clk);
    chk("rst_start.busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 40; i++) begin
      r_op  = 2'($urandom_range(0, 3));
      r_sgn = 1'($urandom_range(0, 1));
      ra    = $urandom;
      case (i % 4)
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 255));
        default: rb = $urandom;
      endcase
      if (i % 5 == 0) ra = 32'($urandom_range(0, 1000));
      rd = 5'($urandom_range(0, 31));
      run_op(r_op, r_sgn, ra, rb, rd, 1'b0);
      chk($sformatf("rnd%0d.wD op%0d a=%h b=%h", i, r_op, ra, rb), got_wd,
          ref_model(r_op, r_sgn, ra, rb));
      chk($sformatf("rnd%0d.done_cnt", i), got_done_cnt, 32'd1);
      chk($sformatf("rnd%0d.we", i), {31'd0, got_we}, {31'd0, (rd != 5'd0)});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
